uart_fifo_arb: RTL and testbench
================================

Name: uart_fifo_arb

Overview:
Two-requester, packet-locked round-robin arbiter in front of the UART TX byte FIFO (pmi_fifo, LUT, noreg). It merges two byte streams (e.g. MCU console and debug/status source) into the single FIFO write port. A grant is held for a whole packet, so bytes from different sources never interleave. A watchdog releases a requester that stalls mid-packet.

Parameters:
DATA_WIDTH, 8, byte width; must match the FIFO pmi_data_width.
TIMEOUT, 255, stall cycles tolerated mid-packet before forced release; 0 disables the watchdog; max 65535.

Ports:
Clock  in  1  system clock.
Reset  in  1  asynchronous, active-high reset.
req0_data  in  DATA_WIDTH  requester 0 byte.
req0_valid  in  1  requester 0 byte valid.
req0_last  in  1  marks the final byte of a packet.
req0_ready  out  1  requester 0 byte accepted this cycle.
req1_data, req1_valid, req1_last, req1_ready: same as requester 0, for requester 1.
fifo_data  out  DATA_WIDTH  to FIFO Data.
fifo_wren  out  1  to FIFO WrEn.
fifo_full  in  1  from FIFO Full.
grant  out  2  one-hot active grant; 00 when idle.
timeout_err  out  1  one-cycle pulse on forced release.
timeout_src  out  1  requester released by the last timeout; sticky until the next timeout.

Behaviour:
- Reset (asynchronous assert, synchronous-to-Clock deassert handled upstream) sets:
  - state=IDLE, grant=00, last_served=1 (requester 0 wins the first tie).
  - watchdog count=0, timeout_err=0, timeout_src=0.
  - fifo_wren=0 and both ready=0 while Reset is high.
- States: IDLE, LOCKED.
- IDLE:
  - Outputs: no writes; readies=0.
  - If exactly one valid is high, register grant to that requester and go to LOCKED.
  - If both are high, grant the requester != last_served.
  - Arbitration costs exactly 1 cycle: the first byte transfers at the earliest on the cycle after the grant.
- LOCKED (granted requester g):
  - req_g_ready = !fifo_full.
  - fifo_wren = req_g_valid & !fifo_full.
  - fifo_data = req_g_data (combinational mux).
  - The non-granted requester's ready=0. fifo_data is don't-care when fifo_wren=0.
  - Accepted beat = req_g_valid & req_g_ready.
  - Accepted beat with req_g_last=1: next state IDLE, grant=00, last_served=g.
- Back-to-back: a packet costs payload_bytes + 1 cycles minimum; a single-byte packet takes 2 cycles.
- Full handling:
  - The FIFO (noreg) updates Full on the same edge as the write, so combinational gating by fifo_full is exact.
  - A write is never issued while fifo_full=1. Full backpressure never drops or duplicates a byte.
  - almost_full is not used.
- Watchdog (LOCKED only):
  - count clears on every accepted beat and on entry to LOCKED.
  - count increments on cycles where req_g_valid=0. Cycles stalled by fifo_full do not count, because that is downstream backpressure.
  - When count reaches TIMEOUT: go to IDLE, grant=00, last_served=g, timeout_err=1 for one cycle, timeout_src=g.
  - The partial packet already in the FIFO is not recalled.
  - A beat accepted in the same cycle that count would reach TIMEOUT wins: count clears and there is no timeout.
- Simultaneous last-byte and new requests: the next arbitration happens in the following IDLE cycle using the updated last_served.
- Reset asserted mid-packet: the packet is abandoned immediately, with no further writes.
- Requesters must hold data/valid stable until ready; the arbiter does not check this.

Decomposition:
- Shared package uart_fifo_arb_pkg holds:
  - state enum {IDLE, LOCKED};
  - GRANT_NONE=2'b00, GRANT_0=2'b01, GRANT_1=2'b10;
  - watchdog counter width = 16.
- One natural sub-module: uart_arb_watchdog. It holds the clear/increment/terminal-count counter with the TIMEOUT parameter, and TIMEOUT=0 ties its terminal-count output low.
- Round-robin select and the mux stay inline.

Test Plan:
1. Reset, then req0 sends a 3-byte packet 0x41,0x42,0x43 (last on 0x43) with fifo_full=0 -> grant=01 one cycle after valid; fifo_wren high for 3 consecutive cycles with data 0x41,0x42,0x43; grant=00 on the next cycle.
2. Both requesters valid in the same cycle after reset (req0: 2 bytes, req1: 1 byte) -> req0 served first, then req1. A second tie is then served req0 first again, since last_served=1.
3. req1 packet of 4 bytes, fifo_full forced high for 5 cycles after the 2nd byte -> fifo_wren=0 and req1_ready=0 during full; exactly 4 writes in order; timeout_err stays 0 with TIMEOUT=3.
4. TIMEOUT=3; req0 sends 1 byte without last, then drops valid -> timeout_err pulses exactly 3 cycles after the accepted byte; timeout_src=0; grant=00. A pending req1 is granted on the next cycle.
5. Single-byte packets with valid+last held continuously on both requesters -> strict alternation 0,1,0,1; one write every 2 cycles.
6. Assert Reset mid-packet on byte 2 of 5 -> fifo_wren falls immediately (asynchronously); after release, grant=00 and no residual writes occur.

Source files
------------

// File: rtl/uart_fifo_arb_pkg.sv
// rtl/uart_fifo_arb_pkg.sv - shared types and constants for the UART TX FIFO arbiter
package uart_fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;

    localparam int WDOG_WIDTH = 16;

endpackage

// File: rtl/uart_arb_watchdog.sv
// rtl/uart_arb_watchdog.sv - stall counter that flags a requester idling mid-packet
module uart_arb_watchdog
    import uart_fifo_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam bit                    ENABLED = (TIMEOUT != 0);
    localparam logic [WDOG_WIDTH-1:0] LIMIT   = WDOG_WIDTH'(TIMEOUT - 1);

    logic [WDOG_WIDTH-1:0] count;

    // Fires on the cycle whose increment would make count equal TIMEOUT.
    assign expire = ENABLED && inc && (count == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_fifo_arb.sv
// rtl/uart_fifo_arb.sv - packet-locked round-robin merge of two byte streams into the TX FIFO
module uart_fifo_arb
    import uart_fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_valid,
    input  logic                  req0_last,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_valid,
    input  logic                  req1_last,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_wren,
    input  logic                  fifo_full,
    output logic [1:0]            grant,
    output logic                  timeout_err,
    output logic                  timeout_src
);

    logic state;
    logic last_served;
    logic locked;
    logic sel;
    logic g_valid;
    logic g_last;
    logic beat;
    logic wd_clear;
    logic wd_inc;
    logic wd_expire;

    // Outputs derive only from async-reset state, so they drop the instant rst rises.
    always_comb begin
        locked     = (state == LOCKED);
        sel        = grant[1];
        g_valid    = sel ? req1_valid : req0_valid;
        g_last     = sel ? req1_last  : req0_last;
        fifo_data  = sel ? req1_data  : req0_data;
        fifo_wren  = locked & g_valid & ~fifo_full;
        req0_ready = locked & grant[0] & ~fifo_full;
        req1_ready = locked & grant[1] & ~fifo_full;
        beat       = fifo_wren;
        wd_clear   = ~locked | beat;
        wd_inc     = locked & ~g_valid;
    end

    uart_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (wd_clear),
        .inc   (wd_inc),
        .expire(wd_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= GRANT_NONE;
            last_served <= 1'b1;
            timeout_err <= 1'b0;
            timeout_src <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (state == IDLE) begin
                // On a tie the requester that was not served last wins.
                if (req0_valid && (!req1_valid || last_served)) begin
                    grant <= GRANT_0;
                    state <= LOCKED;
                end else if (req1_valid) begin
                    grant <= GRANT_1;
                    state <= LOCKED;
                end
            end else begin
                if (beat && g_last) begin
                    state       <= IDLE;
                    grant       <= GRANT_NONE;
                    last_served <= sel;
                end else if (wd_expire && !beat) begin
                    state       <= IDLE;
                    grant       <= GRANT_NONE;
                    last_served <= sel;
                    timeout_err <= 1'b1;
                    timeout_src <= sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo_arb.sv
// tb/tb_uart_fifo_arb.sv - scoreboard bench for the UART TX FIFO arbiter
module tb_uart_fifo_arb;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic       src;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] req0_data;
    logic       req0_valid;
    logic       req0_last;
    logic       req0_ready;
    logic [7:0] req1_data;
    logic       req1_valid;
    logic       req1_last;
    logic       req1_ready;
    logic [7:0] fifo_data;
    logic       fifo_wren;
    logic       fifo_full;
    logic [1:0] grant;
    logic       timeout_err;
    logic       timeout_src;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    tmo_cnt = 0;
    logic  acc0 = 1'b0;
    logic  acc1 = 1'b0;
    beat_t tx0_q[$];
    beat_t tx1_q[$];
    exp_t  exp_q[$];
    int    wr_times[$];

    uart_fifo_arb #(
        .DATA_WIDTH(8),
        .TIMEOUT   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .fifo_data  (fifo_data),
        .fifo_wren  (fifo_wren),
        .fifo_full  (fifo_full),
        .grant      (grant),
        .timeout_err(timeout_err),
        .timeout_src(timeout_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed hang, expected completion");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_tx(input int src, input logic [7:0] data, input logic last, input bit expect_write);
        beat_t b;
        exp_t  e;
        b.data = data;
        b.last = last;
        e.data = data;
        e.src  = (src != 0);
        if (src == 0) tx0_q.push_back(b);
        else          tx1_q.push_back(b);
        if (expect_write) exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || tx0_q.size() != 0 || tx1_q.size() != 0 || grant !== 2'b00) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, (n < 200), 1);
    endtask

    task automatic wait_write(input string tag, input logic [7:0] data, input logic [1:0] g);
        int n = 0;
        while (!(fifo_wren === 1'b1 && fifo_data === data && grant === g) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < 100), 1);
    endtask

    // Requester models: advance on acceptance, present the queue head just after each edge.
    initial forever begin
        @(negedge clk);
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (acc0 && tx0_q.size() > 0) void'(tx0_q.pop_front());
        if (acc1 && tx1_q.size() > 0) void'(tx1_q.pop_front());
        if (tx0_q.size() > 0) begin
            req0_valid = 1'b1;
            req0_data  = tx0_q[0].data;
            req0_last  = tx0_q[0].last;
        end else begin
            req0_valid = 1'b0;
            req0_data  = 8'h00;
            req0_last  = 1'b0;
        end
        if (tx1_q.size() > 0) begin
            req1_valid = 1'b1;
            req1_data  = tx1_q[0].data;
            req1_last  = tx1_q[0].last;
        end else begin
            req1_valid = 1'b0;
            req1_data  = 8'h00;
            req1_last  = 1'b0;
        end
    end

    // FIFO-side scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (fifo_wren === 1'b1) begin
                wr_times.push_back(cyc);
                check("wren_while_full", fifo_full, 0);
                check("write_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_data", fifo_data, e.data);
                    check("wr_src", grant, e.src ? 2'b10 : 2'b01);
                end
            end
            if (timeout_err === 1'b1) tmo_cnt++;
        end
    end

    initial begin
        int base;
        int tbase;
        rst        = 1'b1;
        fifo_full  = 1'b0;
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req0_last  = 1'b0;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        req1_last  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_wren", fifo_wren, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_tmo_err", timeout_err, 0);
        check("rst_tmo_src", timeout_src, 0);
        rst = 1'b0;

        // Single 3-byte packet from requester 0.
        @(negedge clk);
        push_tx(0, 8'h41, 1'b0, 1);
        push_tx(0, 8'h42, 1'b0, 1);
        push_tx(0, 8'h43, 1'b1, 1);
        @(negedge clk);
        check("t1_arb_grant", grant, 2'b00);
        check("t1_arb_valid", req0_valid, 1);
        @(negedge clk);
        check("t1_grant", grant, 2'b01);
        check("t1_b0_wren", fifo_wren, 1);
        check("t1_b0_data", fifo_data, 8'h41);
        @(negedge clk);
        check("t1_b1_wren", fifo_wren, 1);
        check("t1_b1_data", fifo_data, 8'h42);
        @(negedge clk);
        check("t1_b2_wren", fifo_wren, 1);
        check("t1_b2_data", fifo_data, 8'h43);
        @(negedge clk);
        check("t1_release", grant, 2'b00);
        check("t1_idle_wren", fifo_wren, 0);
        drain("t1_drain");

        // Ties straight after reset, then again with last_served back at 1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_tx(0, 8'h10, 1'b0, 1);
        push_tx(0, 8'h11, 1'b1, 1);
        push_tx(1, 8'h20, 1'b1, 1);
        drain("t2_tie1_drain");
        push_tx(0, 8'h30, 1'b1, 1);
        push_tx(1, 8'h40, 1'b1, 1);
        drain("t2_tie2_drain");

        // Full backpressure mid-packet must not trip the watchdog.
        base  = wr_times.size();
        tbase = tmo_cnt;
        push_tx(1, 8'hB0, 1'b0, 1);
        push_tx(1, 8'hB1, 1'b0, 1);
        push_tx(1, 8'hB2, 1'b0, 1);
        push_tx(1, 8'hB3, 1'b1, 1);
        wait_write("t3_wait_b1", 8'hB1, 2'b10);
        @(posedge clk);
        #1;
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_full_wren", fifo_wren, 0);
            check("t3_full_ready1", req1_ready, 0);
            check("t3_full_grant", grant, 2'b10);
        end
        @(posedge clk);
        #1;
        fifo_full = 1'b0;
        drain("t3_drain");
        check("t3_write_count", wr_times.size() - base, 4);
        check("t3_no_timeout", tmo_cnt - tbase, 0);

        // Requester 0 stalls mid-packet; requester 1 waits behind it.
        tbase = tmo_cnt;
        push_tx(0, 8'h55, 1'b0, 1);
        wait_write("t4_wait_byte", 8'h55, 2'b01);
        push_tx(1, 8'h66, 1'b1, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("t4_no_err_yet", timeout_err, 0);
            check("t4_still_locked", grant, 2'b01);
        end
        @(negedge clk);
        check("t4_err_pulse", timeout_err, 1);
        check("t4_err_src", timeout_src, 0);
        check("t4_err_grant", grant, 2'b00);
        @(negedge clk);
        check("t4_err_single", timeout_err, 0);
        check("t4_next_grant", grant, 2'b10);
        check("t4_next_wren", fifo_wren, 1);
        check("t4_next_data", fifo_data, 8'h66);
        drain("t4_drain");
        check("t4_pulse_count", tmo_cnt - tbase, 1);
        check("t4_src_sticky", timeout_src, 0);

        // Continuous single-byte packets on both sides alternate at one write per 2 cycles.
        base = wr_times.size();
        for (int i = 0; i < 4; i++) begin
            push_tx(0, 8'hC0 + 8'(i), 1'b1, 1);
            push_tx(1, 8'hD0 + 8'(i), 1'b1, 1);
        end
        drain("t5_drain");
        check("t5_write_count", wr_times.size() - base, 8);
        if (wr_times.size() - base == 8) begin
            for (int i = 1; i < 8; i++) begin
                check("t5_spacing", wr_times[base+i] - wr_times[base+i-1], 2);
            end
        end

        // Reset during byte 2 of a 5-byte packet.
        push_tx(0, 8'hA0, 1'b0, 1);
        push_tx(0, 8'hA1, 1'b0, 0);
        push_tx(0, 8'hA2, 1'b0, 0);
        push_tx(0, 8'hA3, 1'b0, 0);
        push_tx(0, 8'hA4, 1'b1, 0);
        wait_write("t6_wait_a0", 8'hA0, 2'b01);
        @(posedge clk);
        #2;
        check("t6_mid_wren", fifo_wren, 1);
        check("t6_mid_data", fifo_data, 8'hA1);
        rst = 1'b1;
        #1;
        check("t6_async_wren", fifo_wren, 0);
        check("t6_async_ready0", req0_ready, 0);
        check("t6_async_grant", grant, 2'b00);
        tx0_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_post_grant", grant, 2'b00);
            check("t6_post_wren", fifo_wren, 0);
        end
        check("t6_scoreboard_empty", exp_q.size(), 0);
        check("t6_src_cleared", timeout_src, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
